// File: rtl/tile_pkg.sv
// tile_pkg: shared board geometry, cell index type and selector state type
// for the tile selection path.
package tile_pkg;

    localparam int GRID_W = 6;
    localparam int GRID_H = 6;
    localparam int CELLS  = GRID_W * GRID_H;
    localparam int IDX_W  = 6;

    typedef logic [IDX_W-1:0] cell_idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ONE  = 2'd1,
        PAIR = 2'd2
    } sel_state_t;

endpackage

// File: rtl/tile_selector_onehot_decode.sv
// onehot_decode: combinational decode of a one-hot cursor bus.
//   bus       in   CELLS  one-hot cursor, bit i = cell i
//   cur_idx   out  IDX_W  position of the set bit (meaningful only when valid)
//   cur_valid out  1      exactly one bit of bus is set
module onehot_decode
    import tile_pkg::*;
#(
    parameter int CELLS = tile_pkg::CELLS,
    parameter int IDX_W = tile_pkg::IDX_W
) (
    input  logic [CELLS-1:0] bus,
    output logic [IDX_W-1:0] cur_idx,
    output logic             cur_valid
);

    // Saturating count of set bits: 0, 1, or "2 or more".
    logic [1:0] hits;

    always_comb begin
        hits    = '0;
        cur_idx = '0;
        for (int unsigned i = 0; i < CELLS; i++) begin
            if (bus[i]) begin
                cur_idx = IDX_W'(i);
                if (hits != 2'd2) begin
                    hits = hits + 2'd1;
                end
            end
        end
    end

    assign cur_valid = (hits == 2'd1);

endmodule

// File: rtl/tile_selector.sv
// tile_selector: captures two player picks from the one-hot cursor bus and
// offers them as a pair to the match checker via valid/ready.
//   clk, rst     clock, synchronous active-high reset
//   cur_bus      one-hot cursor position (row-major cell index)
//   sel          debounced select button (level; acted on at rising edge)
//   clear        abandon any selection, withdraw an unaccepted pair
//   first_idx    index of the first pick
//   second_idx   index of the second pick
//   pair_valid   pair offered to the checker
//   pair_ready   checker accepts the pair
//   sel_bus      highlight of the selected cell(s)
//   bad_cur      one-cycle pulse on a select edge with an invalid cursor
//   timeout      one-cycle pulse when the first pick expires
// Optional first-pick expiry is enabled by defining TILE_SELECTOR_TIMEOUT_EN;
// without it the timer is absent and timeout is constant 0.
module tile_selector
    import tile_pkg::*;
#(
    parameter int GRID_W         = tile_pkg::GRID_W,
    parameter int GRID_H         = tile_pkg::GRID_H,
    parameter int CELLS          = GRID_W * GRID_H,
    parameter int IDX_W          = tile_pkg::IDX_W,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CELLS-1:0] cur_bus,
    input  logic             sel,
    input  logic             clear,
    output logic [IDX_W-1:0] first_idx,
    output logic [IDX_W-1:0] second_idx,
    output logic             pair_valid,
    input  logic             pair_ready,
    output logic [CELLS-1:0] sel_bus,
    output logic             bad_cur,
    output logic             timeout
);

    sel_state_t       state;
    logic             sel_q;
    logic             sel_edge;
    logic [IDX_W-1:0] cur_idx;
    logic             cur_valid;
    logic             pick;

    onehot_decode #(
        .CELLS (CELLS),
        .IDX_W (IDX_W)
    ) u_decode (
        .bus       (cur_bus),
        .cur_idx   (cur_idx),
        .cur_valid (cur_valid)
    );

    // sel_q resets to 0, so a sel already high right after reset is an edge.
    assign sel_edge = sel & ~sel_q;
    assign pick     = sel_edge & cur_valid;

`ifdef TILE_SELECTOR_TIMEOUT_EN
    logic [31:0] timer;
    logic        timeout_q;
    logic        expired;

    // Timer is 0 on the first cycle in ONE and counts up while there.
    assign expired = (state == ONE) && (timer == 32'(TIMEOUT_CYCLES - 1));
    assign timeout = timeout_q;

    always_ff @(posedge clk) begin
        if (rst || state != ONE) begin
            timer <= '0;
        end else begin
            timer <= timer + 32'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            first_idx  <= '0;
            second_idx <= '0;
            pair_valid <= 1'b0;
            sel_bus    <= '0;
            bad_cur    <= 1'b0;
            sel_q      <= 1'b0;
`ifdef TILE_SELECTOR_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
        end else begin
            sel_q   <= sel;
            bad_cur <= 1'b0;
`ifdef TILE_SELECTOR_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            if (clear) begin
                // Also covers clear+pair_ready: the handshake completes anyway,
                // since both paths end in IDLE with the pair dropped.
                state      <= IDLE;
                sel_bus    <= '0;
                pair_valid <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (pick) begin
                            first_idx <= cur_idx;
                            sel_bus   <= CELLS'(1) << cur_idx;
                            state     <= ONE;
                        end else if (sel_edge) begin
                            bad_cur <= 1'b1;
                        end
                    end
                    ONE: begin
                        if (pick && cur_idx == first_idx) begin
                            sel_bus <= '0;
                            state   <= IDLE;
                        end else if (pick) begin
                            second_idx <= cur_idx;
                            sel_bus    <= sel_bus | (CELLS'(1) << cur_idx);
                            pair_valid <= 1'b1;
                            state      <= PAIR;
                        end else begin
                            if (sel_edge) begin
                                bad_cur <= 1'b1;
                            end
`ifdef TILE_SELECTOR_TIMEOUT_EN
                            if (expired) begin
                                sel_bus   <= '0;
                                timeout_q <= 1'b1;
                                state     <= IDLE;
                            end
`endif
                        end
                    end
                    PAIR: begin
                        if (pair_ready) begin
                            pair_valid <= 1'b0;
                            sel_bus    <= '0;
                            state      <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
